// File: rtl/canonical_form_reduction_pkg.sv
// Shared definitions for the canonical-form reducer: literal encodings, FSM states
// and the Aaronson-Gottesman phase exponent used when multiplying Pauli rows.
package canonical_pkg;

  localparam logic [1:0] LIT_I = 2'b00;
  localparam logic [1:0] LIT_Z = 2'b01;
  localparam logic [1:0] LIT_X = 2'b10;
  localparam logic [1:0] LIT_Y = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XSCAN,
    XELIM,
    ZSCAN,
    ZELIM,
    OUT
  } canon_state_t;

  // Exponent of i picked up when litA is left-multiplied onto litB, in {-1,0,+1}.
  function automatic logic signed [1:0] gPhase(input logic [1:0] litA, input logic [1:0] litB);
    logic signed [1:0] g;
    g = 2'sb00;
    case (litA)
      LIT_X: begin
        if (litB == LIT_Z) g = 2'sb11;
        else if (litB == LIT_Y) g = 2'sb01;
      end
      LIT_Y: begin
        if (litB == LIT_Z) g = 2'sb01;
        else if (litB == LIT_X) g = 2'sb11;
      end
      LIT_Z: begin
        if (litB == LIT_X) g = 2'sb01;
        else if (litB == LIT_Y) g = 2'sb11;
      end
      default: g = 2'sb00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/canonical_form_reduction_if.sv
// Row-stream bundle between the conjugation stage, the reducer and the stabilizer array.
interface canonical_form_reduction_if #(parameter int NUM_QUBIT = 4);

  logic [NUM_QUBIT-1:0][1:0]      literals_in;
  logic [(1 << NUM_QUBIT)-1:0]    phase_in;
  logic                           valid_in;
  logic                           ready_in;
  logic [NUM_QUBIT-1:0][1:0]      literals_out;
  logic [(1 << NUM_QUBIT)-1:0]    phase_out;
  logic                           valid_out;
  logic                           busy;

  modport master (
    output literals_in, phase_in, valid_in,
    input  ready_in, literals_out, phase_out, valid_out, busy
  );

  modport slave (
    input  literals_in, phase_in, valid_in,
    output ready_in, literals_out, phase_out, valid_out, busy
  );

endinterface

// File: rtl/canonical_form_reduction_pauli_row_multiply.sv
// Combinational product of two commuting Pauli rows: literals XOR, and the phase
// vector flips entirely when the accumulated exponent is 2 mod 4.
module pauli_row_multiply import canonical_pkg::*; #(
  parameter int NUM_QUBIT = 4
) (
  input  logic [NUM_QUBIT-1:0][1:0]   litA_i,
  input  logic [(1 << NUM_QUBIT)-1:0] phaseA_i,
  input  logic [NUM_QUBIT-1:0][1:0]   litB_i,
  input  logic [(1 << NUM_QUBIT)-1:0] phaseB_i,
  output logic [NUM_QUBIT-1:0][1:0]   lit_o,
  output logic [(1 << NUM_QUBIT)-1:0] phase_o
);

  localparam int PH_W  = 1 << NUM_QUBIT;
  localparam int SUM_W = $clog2(NUM_QUBIT) + 2;

  logic [SUM_W-1:0]  expSum;
  logic signed [1:0] gVal;
  logic              signFlip;

  always_comb begin
    expSum = '0;
    gVal   = 2'sb00;
    lit_o  = '0;
    for (int c = 0; c < NUM_QUBIT; c++) begin
      gVal     = gPhase(litA_i[c], litB_i[c]);
      expSum   = expSum + {{(SUM_W-2){gVal[1]}}, gVal};
      lit_o[c] = litA_i[c] ^ litB_i[c];
    end
  end

  assign signFlip = ((expSum & SUM_W'(3)) == SUM_W'(2));
  assign phase_o  = phaseA_i ^ phaseB_i ^ {PH_W{signFlip}};

endmodule

// File: rtl/canonical_form_reduction.sv
// Gaussian-elimination reducer: loads num_qubit rows, runs an X/Y pass then a Z pass,
// and streams the canonical tableau out. Define CANONICAL_DEBUG_EN to expose the live tableau and pivot count.
module canonical_form_reduction import canonical_pkg::*; #(
  parameter int NUM_QUBIT = 4
) (
  input logic clk,
  input logic rst,
  canonical_form_reduction_if.slave bus
`ifdef CANONICAL_DEBUG_EN
  ,
  output logic [NUM_QUBIT-1:0][NUM_QUBIT-1:0][1:0] literal_reg_canonical,
  output logic [$clog2(NUM_QUBIT+1)-1:0]           pivot_count
`endif
);

  localparam int PH_W  = 1 << NUM_QUBIT;
  localparam int PTR_W = $clog2(NUM_QUBIT + 1);
  localparam int ROW_W = $clog2(NUM_QUBIT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_QUBIT - 1);

  canon_state_t state_q, state_d;

  logic [NUM_QUBIT-1:0][NUM_QUBIT-1:0][1:0] tableau_q, tableau_d;
  logic [NUM_QUBIT-1:0][PH_W-1:0]           phase_q, phase_d;
  logic [PTR_W-1:0] iPtr_q, iPtr_d, jPtr_q, jPtr_d;
  logic [PTR_W-1:0] rowCnt_q, rowCnt_d, outCnt_q, outCnt_d;

  logic [ROW_W-1:0] iRow, jCol, pivotRow;
  logic             pivotFound;
  logic [NUM_QUBIT-1:0] elimMask;
  logic [1:0]       colLit;
  logic [NUM_QUBIT-1:0][NUM_QUBIT-1:0][1:0] prodLit;
  logic [NUM_QUBIT-1:0][PH_W-1:0]           prodPhase;

  assign iRow = iPtr_q[ROW_W-1:0];
  assign jCol = jPtr_q[ROW_W-1:0];

  // Pivot search (lowest row at or below i) and the set of rows to clear in column j.
  always_comb begin
    pivotFound = 1'b0;
    pivotRow   = '0;
    elimMask   = '0;
    colLit     = LIT_I;
    for (int k = NUM_QUBIT - 1; k >= 0; k--) begin
      colLit = tableau_q[k][jCol];
      if ((PTR_W'(k) >= iPtr_q) &&
          (((state_q == XSCAN) && colLit[1]) || ((state_q == ZSCAN) && (colLit == LIT_Z)))) begin
        pivotFound = 1'b1;
        pivotRow   = ROW_W'(k);
      end
      if ((ROW_W'(k) != iRow) &&
          (((state_q == XELIM) && colLit[1]) || ((state_q == ZELIM) && colLit[0]))) begin
        elimMask[k] = 1'b1;
      end
    end
  end

  for (genvar m = 0; m < NUM_QUBIT; m++) begin : gMul
    pauli_row_multiply #(.NUM_QUBIT(NUM_QUBIT)) uMul (
      .litA_i   (tableau_q[iRow]),
      .phaseA_i (phase_q[iRow]),
      .litB_i   (tableau_q[m]),
      .phaseB_i (phase_q[m]),
      .lit_o    (prodLit[m]),
      .phase_o  (prodPhase[m])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A pass ends on the last column or once every row holds a pivot; full rank skips the Z pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: if (bus.valid_in) state_d = (rowCnt_q == LAST_IDX) ? XSCAN : LOAD;
      XSCAN: begin
        if (pivotFound)                state_d = XELIM;
        else if (jPtr_q == LAST_IDX)   state_d = ZSCAN;
      end
      XELIM: begin
        if (iPtr_q == LAST_IDX)        state_d = OUT;
        else if (jPtr_q == LAST_IDX)   state_d = ZSCAN;
        else                           state_d = XSCAN;
      end
      ZSCAN: begin
        if (pivotFound)                state_d = ZELIM;
        else if (jPtr_q == LAST_IDX)   state_d = OUT;
      end
      ZELIM: state_d = ((iPtr_q == LAST_IDX) || (jPtr_q == LAST_IDX)) ? OUT : ZSCAN;
      OUT:   if (outCnt_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_in     = 1'b0;
    bus.valid_out    = 1'b0;
    bus.busy         = 1'b0;
    bus.literals_out = '0;
    bus.phase_out    = '0;
    case (state_q)
      IDLE: bus.ready_in = 1'b1;
      LOAD: begin
        bus.ready_in = 1'b1;
        bus.busy     = 1'b1;
      end
      OUT: begin
        bus.valid_out    = 1'b1;
        bus.busy         = 1'b1;
        bus.literals_out = tableau_q[outCnt_q[ROW_W-1:0]];
        bus.phase_out    = phase_q[outCnt_q[ROW_W-1:0]];
      end
      default: bus.busy = 1'b1;
    endcase
  end

  // j wraps to 0 at the end of a pass so the Z pass starts at column 0 with i kept.
  always_comb begin
    tableau_d = tableau_q;
    phase_d   = phase_q;
    iPtr_d    = iPtr_q;
    jPtr_d    = jPtr_q;
    rowCnt_d  = rowCnt_q;
    outCnt_d  = outCnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (bus.valid_in) begin
          tableau_d[rowCnt_q[ROW_W-1:0]] = bus.literals_in;
          phase_d[rowCnt_q[ROW_W-1:0]]   = bus.phase_in;
          if (rowCnt_q == LAST_IDX) begin
            rowCnt_d = '0;
            iPtr_d   = '0;
            jPtr_d   = '0;
          end else begin
            rowCnt_d = rowCnt_q + 1'b1;
          end
        end
      end
      XSCAN, ZSCAN: begin
        if (pivotFound) begin
          tableau_d[pivotRow] = tableau_q[iRow];
          tableau_d[iRow]     = tableau_q[pivotRow];
          phase_d[pivotRow]   = phase_q[iRow];
          phase_d[iRow]       = phase_q[pivotRow];
        end else begin
          jPtr_d = (jPtr_q == LAST_IDX) ? '0 : jPtr_q + 1'b1;
        end
      end
      XELIM, ZELIM: begin
        for (int m = 0; m < NUM_QUBIT; m++) begin
          if (elimMask[m]) begin
            tableau_d[m] = prodLit[m];
            phase_d[m]   = prodPhase[m];
          end
        end
        iPtr_d = iPtr_q + 1'b1;
        jPtr_d = (jPtr_q == LAST_IDX) ? '0 : jPtr_q + 1'b1;
      end
      OUT: outCnt_d = (outCnt_q == LAST_IDX) ? '0 : outCnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tableau_q <= '0;
      phase_q   <= '0;
      iPtr_q    <= '0;
      jPtr_q    <= '0;
      rowCnt_q  <= '0;
      outCnt_q  <= '0;
    end else begin
      tableau_q <= tableau_d;
      phase_q   <= phase_d;
      iPtr_q    <= iPtr_d;
      jPtr_q    <= jPtr_d;
      rowCnt_q  <= rowCnt_d;
      outCnt_q  <= outCnt_d;
    end
  end

`ifdef CANONICAL_DEBUG_EN
  logic [PTR_W-1:0] pivotCount_q;

  // Final rank is captured as the machine enters OUT and held until the next reduction.
  always_ff @(posedge clk) begin
    if (rst)                                       pivotCount_q <= '0;
    else if ((state_d == OUT) && (state_q != OUT)) pivotCount_q <= iPtr_d;
  end

  assign literal_reg_canonical = tableau_q;
  assign pivot_count           = pivotCount_q;
`endif

endmodule
